axi_lite_mem_arbiter: RTL and testbench

// - Shares one AXI4-lite memory slave (axi4_memory) between NM requesters, e.g. the picorv32 core and a loader/DMA master.
// - Round-robin arbitration, one transaction in flight. Sits between the masters and the memory inside the test wrapper.

---
 rtl/axi_arb_pkg.sv | 19 +
 rtl/rr_arbiter_onehot.sv | 11 +
 rtl/axi_lite_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi_lite_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types, channel widths and the round-robin pick helper for axi_lite_mem_arbiter
package axi_arb_pkg;
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA} state_t;
  localparam int AXI_PROT_W = 3;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = 4;
  // One-hot winner: first set bit of req at or above ptr, wrapping modulo nm.
  // Scanning downward lets the nearest requester overwrite farther ones.
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int nm = 8);
    logic [7:0] g;
    int idx;
    g = '0;
    for (int k = nm - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % nm;
      if (req[idx]) g = 8'(1) << idx;
    end
    return g;
  endfunction
endpackage

// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot: combinational round-robin pick; req/ptr in, one-hot grant out
module rr_arbiter_onehot import axi_arb_pkg::*; #(
  parameter int NM = 2,
  parameter int PW = $clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [PW-1:0] ptr,
  output logic [NM-1:0] grant
);
  assign grant = NM'(rr_pick(8'(req), 3'(ptr), NM));
endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// axi_lite_mem_arbiter: round-robin share of one AXI4-lite memory slave among NM masters, one transaction in flight
// Ports: clk, resetn (sync, active-low); s_* per-master channels packed with master i in slice i;
// m_* single-master channels to the slave; grant one-hot owner (0 when idle).
// Optional macro AXI_ARB_STATS_EN adds stat_grants / stat_wait_max (NM x 16-bit saturating counters).
module axi_lite_mem_arbiter import axi_arb_pkg::*; #(
  parameter int NM = 2,
  parameter int AW = 32,
  parameter int MAX_HOLD = 15
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NM-1:0]            s_awvalid,
  output logic [NM-1:0]            s_awready,
  input  logic [NM*AW-1:0]         s_awaddr,
  input  logic [NM*AXI_PROT_W-1:0] s_awprot,
  input  logic [NM-1:0]            s_wvalid,
  output logic [NM-1:0]            s_wready,
  input  logic [NM*AXI_DATA_W-1:0] s_wdata,
  input  logic [NM*AXI_STRB_W-1:0] s_wstrb,
  output logic [NM-1:0]            s_bvalid,
  input  logic [NM-1:0]            s_bready,
  input  logic [NM-1:0]            s_arvalid,
  output logic [NM-1:0]            s_arready,
  input  logic [NM*AW-1:0]         s_araddr,
  input  logic [NM*AXI_PROT_W-1:0] s_arprot,
  output logic [NM-1:0]            s_rvalid,
  input  logic [NM-1:0]            s_rready,
  output logic [AXI_DATA_W-1:0]    s_rdata,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  output logic [AW-1:0]            m_awaddr,
  output logic [AXI_PROT_W-1:0]    m_awprot,
  output logic                     m_wvalid,
  input  logic                     m_wready,
  output logic [AXI_DATA_W-1:0]    m_wdata,
  output logic [AXI_STRB_W-1:0]    m_wstrb,
  input  logic                     m_bvalid,
  output logic                     m_bready,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [AW-1:0]            m_araddr,
  output logic [AXI_PROT_W-1:0]    m_arprot,
  input  logic                     m_rvalid,
  output logic                     m_rready,
  input  logic [AXI_DATA_W-1:0]    m_rdata,
  output logic [NM-1:0]            grant
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [NM*16-1:0]         stat_grants,
  output logic [NM*16-1:0]         stat_wait_max
`endif
);
  localparam int PW = $clog2(NM);
  localparam int HW = $clog2(MAX_HOLD + 2);
  state_t state, state_n;
  logic [NM-1:0] req, pick, grant_n;
  logic [PW-1:0] own, own_n, pick_idx, rr_ptr, rr_ptr_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic aw_done, w_done, aw_done_n, w_done_n;
  logic wa, aw_hs, w_hs, b_hs, ar_hs, r_hs, stalled, timeout;
  assign req = s_awvalid | s_arvalid;
  rr_arbiter_onehot #(.NM(NM), .PW(PW)) u_rr (.req(req), .ptr(rr_ptr), .grant(pick));
  assign wa        = state == WR_ADDR;
  assign m_awvalid = wa && !aw_done && s_awvalid[own];
  assign m_awaddr  = s_awaddr[int'(own)*AW +: AW];
  assign m_awprot  = s_awprot[int'(own)*AXI_PROT_W +: AXI_PROT_W];
  assign m_wvalid  = wa && !w_done && s_wvalid[own];
  assign m_wdata   = s_wdata[int'(own)*AXI_DATA_W +: AXI_DATA_W];
  assign m_wstrb   = s_wstrb[int'(own)*AXI_STRB_W +: AXI_STRB_W];
  assign m_bready  = state == WR_RESP && s_bready[own];
  assign m_arvalid = state == RD_ADDR && s_arvalid[own];
  assign m_araddr  = s_araddr[int'(own)*AW +: AW];
  assign m_arprot  = s_arprot[int'(own)*AXI_PROT_W +: AXI_PROT_W];
  assign m_rready  = state == RD_DATA && s_rready[own];
  // The registered one-hot grant masks every per-master handshake signal.
  assign s_awready = grant & {NM{wa && !aw_done && m_awready}};
  assign s_wready  = grant & {NM{wa && !w_done && m_wready}};
  assign s_bvalid  = grant & {NM{state == WR_RESP && m_bvalid}};
  assign s_arready = grant & {NM{state == RD_ADDR && m_arready}};
  assign s_rvalid  = grant & {NM{state == RD_DATA && m_rvalid}};
  assign s_rdata   = m_rdata;
  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;
  assign b_hs  = m_bvalid && m_bready;
  assign ar_hs = m_arvalid && m_arready;
  assign r_hs  = m_rvalid && m_rready;
  // Owner idling before any handshake of its transaction has completed.
  assign stalled = wa ? !(s_awvalid[own] || s_wvalid[own] || aw_done || w_done)
                      : state == RD_ADDR && !s_arvalid[own];
  assign timeout = MAX_HOLD > 0 && stalled && hold_cnt == HW'(MAX_HOLD - 1);
  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NM; k++)
      if (pick[k]) pick_idx = PW'(k);
  end
  always_comb begin
    state_n    = state;
    grant_n    = grant;
    own_n      = own;
    rr_ptr_n   = rr_ptr;
    aw_done_n  = aw_done || aw_hs;
    w_done_n   = w_done || w_hs;
    hold_cnt_n = stalled && MAX_HOLD > 0 ? hold_cnt + 1'b1 : hold_cnt;
    case (state)
      IDLE: if (|req) begin
        grant_n    = pick;
        own_n      = pick_idx;
        aw_done_n  = 1'b0;
        w_done_n   = 1'b0;
        hold_cnt_n = '0;
        state_n    = s_awvalid[pick_idx] ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: state_n = aw_done_n && w_done_n ? WR_RESP : WR_ADDR;
      RD_ADDR: state_n = ar_hs ? RD_DATA : RD_ADDR;
      default: ;
    endcase
    if (b_hs || r_hs || timeout) begin
      state_n  = IDLE;
      grant_n  = '0;
      rr_ptr_n = own == PW'(NM - 1) ? '0 : own + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state    <= IDLE;
      grant    <= '0;
      own      <= '0;
      rr_ptr   <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      own      <= own_n;
      rr_ptr   <= rr_ptr_n;
      aw_done  <= aw_done_n;
      w_done   <= w_done_n;
      hold_cnt <= hold_cnt_n;
    end
`ifdef AXI_ARB_STATS_EN
  logic [NM-1:0][15:0] grants_q, wmax_q, wait_cnt;
  assign stat_grants   = grants_q;
  assign stat_wait_max = wmax_q;
  // wait_cnt counts cycles a master requests while someone else (or nobody yet) holds the grant.
  always_ff @(posedge clk)
    if (!resetn) begin
      grants_q <= '0;
      wmax_q   <= '0;
      wait_cnt <= '0;
    end else
      for (int k = 0; k < NM; k++) begin
        if ((b_hs || r_hs) && own == PW'(k) && grants_q[k] != 16'hFFFF) grants_q[k] <= grants_q[k] + 16'd1;
        if (state == IDLE && |req && pick[k]) begin
          if (wait_cnt[k] > wmax_q[k]) wmax_q[k] <= wait_cnt[k];
          wait_cnt[k] <= '0;
        end else
          wait_cnt[k] <= req[k] && !grant[k] ? wait_cnt[k] + 16'(wait_cnt[k] != 16'hFFFF) : '0;
      end
`endif
endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// tb_axi_lite_mem_arbiter: directed scoreboard bench for axi_lite_mem_arbiter with a behavioural AXI4-lite memory
module tb_axi_lite_mem_arbiter;
  import axi_arb_pkg::*;
  localparam int NM = 2, AW = 32, MAX_HOLD = 4;
  logic clk = 1'b0, resetn = 1'b0;
  always #5 clk = ~clk;
  logic [NM-1:0] s_awvalid = '0, s_wvalid = '0, s_bready = '0, s_arvalid = '0, s_rready = '0;
  logic [NM-1:0] s_awready, s_wready, s_bvalid, s_arready, s_rvalid, grant;
  logic [NM*AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic [NM*3-1:0] s_awprot = '0, s_arprot = '0;
  logic [NM*32-1:0] s_wdata = '0;
  logic [NM*4-1:0] s_wstrb = '0;
  logic [31:0] s_rdata, m_wdata, m_rdata;
  logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0] m_awprot, m_arprot;
  logic [3:0] m_wstrb;
`ifdef AXI_ARB_STATS_EN
  logic [NM*16-1:0] stat_grants, stat_wait_max;
`endif
  axi_lite_mem_arbiter #(.NM(NM), .AW(AW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .grant(grant)
`ifdef AXI_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_wait_max(stat_wait_max)
`endif
  );
  // Behavioural memory slave: accepts aw and w independently, responds one cycle after both arrive.
  logic [31:0] mem [256];
  logic aw_got, w_got;
  logic [AW-1:0] aw_a;
  logic [31:0] w_d;
  logic [3:0] w_s;
  initial for (int k = 0; k < 256; k++) mem[k] = '0;
  assign m_awready = !aw_got && !m_bvalid;
  assign m_wready  = !w_got && !m_bvalid;
  assign m_arready = !m_rvalid;
  always @(posedge clk)
    if (!resetn) begin
      aw_got <= 1'b0; w_got <= 1'b0; m_bvalid <= 1'b0; m_rvalid <= 1'b0; m_rdata <= '0;
    end else begin
      if (m_awvalid && m_awready) begin aw_got <= 1'b1; aw_a <= m_awaddr; end
      if (m_wvalid && m_wready) begin w_got <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb; end
      if (aw_got && w_got) begin
        for (int k = 0; k < 4; k++) if (w_s[k]) mem[aw_a[9:2]][k*8 +: 8] <= w_d[k*8 +: 8];
        m_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin m_rvalid <= 1'b1; m_rdata <= mem[m_araddr[9:2]]; end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
    end
  int tests = 0, failed = 0;
  int b_cnt = 0, r_cnt = 0;
  bit aw_seen = 0, chk_grant = 1;
  int exp_g[$], glog[$];
  logic [31:0] exp_rd0[$], exp_rd1[$];
  logic [NM-1:0] gprev = '0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  // Negedge monitor: counts slave handshakes, pops read-data and grant-order expectations.
  always @(negedge clk) begin
    int gi;
    logic [NM-1:0] eg;
    if (m_bvalid && m_bready) b_cnt++;
    if (m_rvalid && m_rready) r_cnt++;
    if (m_awvalid) aw_seen = 1;
    if (s_rvalid[0] && s_rready[0]) begin
      chk("rd0_expected", 64'(exp_rd0.size() != 0), 1);
      if (exp_rd0.size() != 0) chk("rd0_data", s_rdata, exp_rd0.pop_front());
    end
    if (s_rvalid[1] && s_rready[1]) begin
      chk("rd1_expected", 64'(exp_rd1.size() != 0), 1);
      if (exp_rd1.size() != 0) chk("rd1_data", s_rdata, exp_rd1.pop_front());
    end
    if (grant != 0 && gprev == 0) begin
      gi = 0;
      for (int k = 0; k < NM; k++) if (grant[k]) gi = k;
      glog.push_back(gi);
      if (chk_grant) begin
        chk("grant_expected", 64'(exp_g.size() != 0), 1);
        if (exp_g.size() != 0) begin
          eg = NM'(1) << exp_g.pop_front();
          chk("grant_owner", grant, eg);
        end
      end
    end
    gprev = grant;
  end
  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask
  task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lag);
    int n;
    bit awd, wd, hs_aw, hs_w, hs;
    s_awaddr[m*AW +: AW] = a; s_wdata[m*32 +: 32] = d; s_wstrb[m*4 +: 4] = s;
    s_awvalid[m] = 1'b1; s_wvalid[m] = lag == 0;
    n = 0; awd = 0; wd = 0;
    while (!(awd && wd) && n < 100) begin
      @(negedge clk);
      hs_aw = s_awvalid[m] && s_awready[m];
      hs_w = s_wvalid[m] && s_wready[m];
      @(posedge clk); #1;
      n++;
      if (hs_aw) begin awd = 1; s_awvalid[m] = 1'b0; end
      if (hs_w) begin wd = 1; s_wvalid[m] = 1'b0; end
      if (n == lag && !wd) s_wvalid[m] = 1'b1;
    end
    chk($sformatf("wr%0d_addr_data_done", m), {awd, wd}, 2'b11);
    s_bready[m] = 1'b1; n = 0;
    do begin @(negedge clk); hs = s_bvalid[m]; @(posedge clk); #1; n++; end while (!hs && n < 100);
    s_bready[m] = 1'b0;
    chk($sformatf("wr%0d_resp_done", m), 64'(hs), 1);
  endtask
  task automatic do_read(input int m, input logic [31:0] a, input logic [31:0] exp);
    int n;
    bit hs;
    if (m == 0) exp_rd0.push_back(exp); else exp_rd1.push_back(exp);
    s_araddr[m*AW +: AW] = a; s_arvalid[m] = 1'b1; n = 0;
    do begin @(negedge clk); hs = s_arvalid[m] && s_arready[m]; @(posedge clk); #1; n++; end while (!hs && n < 100);
    s_arvalid[m] = 1'b0;
    chk($sformatf("rd%0d_addr_done", m), 64'(hs), 1);
    s_rready[m] = 1'b1; n = 0;
    do begin @(negedge clk); hs = s_rvalid[m]; @(posedge clk); #1; n++; end while (!hs && n < 100);
    s_rready[m] = 1'b0;
    chk($sformatf("rd%0d_data_done", m), 64'(hs), 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time bound exceeded");
    $fatal(1, "watchdog");
  end
  initial begin
    int base, n, idx, pos;
    do_reset();
    chk("rst_grant", grant, 0);
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    chk("rst_rr_ptr", 64'(dut.rr_ptr), 0);
    chk("rst_hold_cnt", 64'(dut.hold_cnt), 0);
    chk("rst_s_ready", {s_awready, s_wready, s_arready}, 0);
    chk("rst_s_valid", {s_bvalid, s_rvalid}, 0);
    chk("rst_m_valid", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    // single master write then read
    base = b_cnt + r_cnt;
    exp_g.push_back(0); exp_g.push_back(0);
    do_write(0, 32'h100, 32'hDEADBEEF, 4'hF, 0);
    do_read(0, 32'h100, 32'hDEADBEEF);
    chk("t1_grant_idle", grant, 0);
    chk("t1_transactions", 64'(b_cnt + r_cnt - base), 2);
    // aw leads w by 3 cycles; partial-strobe overwrite
    base = b_cnt;
    exp_g.push_back(0);
    do_write(0, 32'h108, 32'h12345678, 4'hF, 3);
    chk("t4_lag_one_b", 64'(b_cnt - base), 1);
    base = b_cnt;
    exp_g.push_back(0);
    do_write(0, 32'h100, 32'hAAAAAAAA, 4'h3, 0);
    chk("t4_same_one_b", 64'(b_cnt - base), 1);
    exp_g.push_back(0); exp_g.push_back(0);
    do_read(0, 32'h108, 32'h12345678);
    do_read(0, 32'h100, 32'hDEADAAAA);
    // simultaneous writes after reset
    do_reset();
    exp_g.push_back(0); exp_g.push_back(1);
    fork
      do_write(0, 32'h200, 32'h11112222, 4'hF, 0);
      do_write(1, 32'h204, 32'h33334444, 4'hF, 0);
    join
    chk("t2_rr_ptr", 64'(dut.rr_ptr), 0);
    exp_g.push_back(0);
    do_read(0, 32'h200, 32'h11112222);
    // continuous reads from master 0 must not starve master 1
    chk_grant = 0;
    idx = 0;
    fork
      repeat (4) do_read(0, 32'h100, 32'hDEADAAAA);
      begin
        repeat (3) @(posedge clk);
        #1 idx = glog.size();
        do_read(1, 32'h204, 32'h33334444);
      end
    join
    pos = -1;
    for (int k = glog.size() - 1; k >= idx; k--) if (glog[k] == 1) pos = k - idx;
    chk("t3_m1_granted", 64'(pos >= 0), 1);
    chk("t3_m1_within_one", 64'(pos <= 1), 1);
    chk_grant = 1;
    // hold timeout: master 1 abandons its address phase
    aw_seen = 0; base = b_cnt;
    exp_g.push_back(1);
    s_awaddr[AW +: AW] = 32'h300; s_awvalid[1] = 1'b1;
    @(posedge clk); #1 s_awvalid[1] = 1'b0;
    chk("t5_granted_m1", grant, 2'b10);
    n = 0;
    while (grant != 0 && n < 20) begin @(negedge clk); if (grant != 0) n++; end
    chk("t5_hold_cycles", 64'(n), 4);
    chk("t5_state_idle", 64'(dut.state), 64'(IDLE));
    chk("t5_no_m_awvalid", 64'(aw_seen), 0);
    chk("t5_no_b", 64'(b_cnt - base), 0);
    chk("t5_rr_ptr", 64'(dut.rr_ptr), 0);
    exp_g.push_back(0);
    do_write(0, 32'h10C, 32'h5A5A5A5A, 4'hF, 0);
    exp_g.push_back(0);
    do_read(0, 32'h10C, 32'h5A5A5A5A);
    // reset while in RD_DATA
    exp_g.push_back(0);
    s_araddr[0 +: AW] = 32'h100; s_arvalid[0] = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!s_rvalid[0] && n < 20);
    chk("t6_in_rd_data", 64'(dut.state), 64'(RD_DATA));
    resetn = 1'b0; s_arvalid[0] = 1'b0;
    @(posedge clk); #1;
    chk("t6_grant", grant, 0);
    chk("t6_state", 64'(dut.state), 64'(IDLE));
    chk("t6_s_ready_valid", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid}, 0);
    chk("t6_m_valid", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    chk("t6_rr_ptr", 64'(dut.rr_ptr), 0);
`ifdef AXI_ARB_STATS_EN
    chk("t6_stat_grants", 64'(stat_grants), 0);
    chk("t6_stat_wait_max", 64'(stat_wait_max), 0);
`endif
    @(posedge clk); #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("end_grant_q_empty", 64'(exp_g.size()), 0);
    chk("end_rd_q_empty", 64'(exp_rd0.size() + exp_rd1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
